// File: rtl/node_port_pkg.sv
// rtl/node_port_pkg.sv - direction codes, FSM state type and data width for the node port controller
package node_port_pkg;

    localparam int DATA_W  = 8;
    localparam int NUM_DIR = 4;

    typedef logic [2:0] dir_code_t;

    localparam dir_code_t DIR_UP    = 3'd0;
    localparam dir_code_t DIR_RIGHT = 3'd1;
    localparam dir_code_t DIR_DOWN  = 3'd2;
    localparam dir_code_t DIR_LEFT  = 3'd3;
    localparam dir_code_t DIR_ANY   = 3'd4;
    localparam dir_code_t DIR_LAST  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_WAIT,
        ST_DONE
    } state_t;

    // LAST is resolved before it is stored, so it never reaches this mapping.
    function automatic logic [NUM_DIR-1:0] dir_mask(input dir_code_t d);
        case (d)
            DIR_UP:    return 4'b0001;
            DIR_RIGHT: return 4'b0010;
            DIR_DOWN:  return 4'b0100;
            DIR_LEFT:  return 4'b1000;
            DIR_ANY:   return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic dir_reserved(input dir_code_t d);
        return (d > DIR_LAST);
    endfunction

endpackage

// File: rtl/node_port_ctrl_if.sv
// rtl/node_port_ctrl_if.sv - execute-path and neighbour handshake bundle for the node port controller
interface node_port_if;
    import node_port_pkg::*;

    logic                            rd_req;
    dir_code_t                       rd_dir;
    logic                            wr_req;
    dir_code_t                       wr_dir;
    logic [DATA_W-1:0]               wr_data;
    logic [NUM_DIR-1:0]              rx_valid;
    logic [NUM_DIR-1:0][DATA_W-1:0]  rx_data;
    logic [NUM_DIR-1:0]              rx_ack;
    logic [NUM_DIR-1:0]              tx_valid;
    logic [NUM_DIR-1:0][DATA_W-1:0]  tx_data;
    logic [NUM_DIR-1:0]              tx_ack;
    logic                            hlt;
    logic                            ackw;
    logic                            rd_done;
    logic [DATA_W-1:0]               rd_data;
    logic                            bad_dir;

    modport master (
        output rd_req, rd_dir, wr_req, wr_dir, wr_data, rx_valid, rx_data, tx_ack,
        input  rx_ack, tx_valid, tx_data, hlt, ackw, rd_done, rd_data, bad_dir
    );

    modport slave (
        input  rd_req, rd_dir, wr_req, wr_dir, wr_data, rx_valid, rx_data, tx_ack,
        output rx_ack, tx_valid, tx_data, hlt, ackw, rd_done, rd_data, bad_dir
    );

endinterface

// File: rtl/node_port_ctrl_arbiter.sv
// rtl/node_port_ctrl_arbiter.sv - 4-way fixed-priority select, lowest index wins
module port_arbiter (
    input  logic [3:0] req_i,
    output logic [3:0] grant_o,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        grant_o = 4'b0000;
        idx_o   = 2'd0;
        valid_o = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_o = 4'b0001 << i;
                idx_o   = 2'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/node_port_ctrl.sv
// rtl/node_port_ctrl.sv - blocking port read/write controller between execute path and four neighbours
module node_port_ctrl
    import node_port_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    node_port_if.slave  bus
);

    state_t                          state_q, state_d;
    dir_code_t                       rd_dir_q, rd_dir_d;
    dir_code_t                       wr_dir_q, wr_dir_d;
    logic [DATA_W-1:0]               wr_data_q, wr_data_d;
    logic [DATA_W-1:0]               rd_data_q, rd_data_d;
    logic                            wr_pend_q, wr_pend_d;
    logic                            rd_done_q, rd_done_d;
    logic                            ackw_q, ackw_d;
    logic                            bad_dir_q, bad_dir_d;
    logic [1:0]                      last_dir_q, last_dir_d;

    logic [NUM_DIR-1:0]              arb_req;
    logic [NUM_DIR-1:0]              arb_grant;
    logic [1:0]                      arb_idx;
    logic                            arb_valid;

    logic [NUM_DIR-1:0]              rx_ack;
    logic [NUM_DIR-1:0]              tx_valid;
    logic [NUM_DIR-1:0][DATA_W-1:0]  tx_data;
    logic                            hlt;
    dir_code_t                       rd_res;
    dir_code_t                       wr_res;

    // Reads and writes never overlap in time, so one arbiter serves both phases.
    port_arbiter u_arb (
        .req_i   (arb_req),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign rd_res = (bus.rd_dir == DIR_LAST) ? {1'b0, last_dir_q} : bus.rd_dir;
    assign wr_res = (bus.wr_dir == DIR_LAST) ? {1'b0, last_dir_q} : bus.wr_dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_dir_q   <= DIR_UP;
            wr_dir_q   <= DIR_UP;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            wr_pend_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            ackw_q     <= 1'b0;
            bad_dir_q  <= 1'b0;
            last_dir_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            rd_dir_q   <= rd_dir_d;
            wr_dir_q   <= wr_dir_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
            wr_pend_q  <= wr_pend_d;
            rd_done_q  <= rd_done_d;
            ackw_q     <= ackw_d;
            bad_dir_q  <= bad_dir_d;
            last_dir_q <= last_dir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_dir_d   = rd_dir_q;
        wr_dir_d   = wr_dir_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = rd_data_q;
        wr_pend_d  = wr_pend_q;
        rd_done_d  = 1'b0;
        ackw_d     = 1'b0;
        bad_dir_d  = bad_dir_q;
        last_dir_d = last_dir_q;
        arb_req    = '0;
        rx_ack     = '0;
        tx_valid   = '0;
        hlt        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hlt = bus.rd_req | bus.wr_req;
                if (bus.rd_req) begin
                    rd_dir_d = rd_res;
                    state_d  = ST_RD_WAIT;
                end
                if (bus.wr_req) begin
                    wr_dir_d  = wr_res;
                    wr_data_d = bus.wr_data;
                    wr_pend_d = 1'b1;
                    if (!bus.rd_req) begin
                        state_d = ST_WR_WAIT;
                    end
                end
                if ((bus.rd_req && dir_reserved(bus.rd_dir)) ||
                    (bus.wr_req && dir_reserved(bus.wr_dir))) begin
                    bad_dir_d = 1'b1;
                end
            end

            ST_RD_WAIT: begin
                hlt     = 1'b1;
                arb_req = bus.rx_valid & dir_mask(rd_dir_q);
                if (dir_reserved(rd_dir_q) || arb_valid) begin
                    rd_done_d = 1'b1;
                    state_d   = wr_pend_q ? ST_WR_WAIT : ST_DONE;
                    if (dir_reserved(rd_dir_q)) begin
                        rd_data_d = '0;
                    end else begin
                        rd_data_d = bus.rx_data[arb_idx];
                        rx_ack    = arb_grant;
                        if (rd_dir_q == DIR_ANY) begin
                            last_dir_d = arb_idx;
                        end
                    end
                end
            end

            ST_WR_WAIT: begin
                hlt      = 1'b1;
                tx_valid = dir_mask(wr_dir_q);
                // Acks on directions we are not offering on are not ours to consume.
                arb_req  = bus.tx_ack & tx_valid;
                if (dir_reserved(wr_dir_q) || arb_valid) begin
                    ackw_d    = 1'b1;
                    wr_pend_d = 1'b0;
                    state_d   = ST_DONE;
                    if (!dir_reserved(wr_dir_q) && (wr_dir_q == DIR_ANY)) begin
                        last_dir_d = arb_idx;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_DIR; i++) begin
            tx_data[i] = tx_valid[i] ? wr_data_q : '0;
        end
    end

    assign bus.rx_ack   = rx_ack;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_data;
    assign bus.hlt      = hlt;
    assign bus.ackw     = ackw_q;
    assign bus.rd_done  = rd_done_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.bad_dir  = bad_dir_q;

endmodule
